// File: rtl/seq_pkg.sv
// Shared definitions for the RV32-subset datapath sequencer: FSM states,
// opcode/funct constants, ALU opcodes, immediate formats, status flag indices
// and the registered control bundle produced by the decoder.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_HALT
    } instr_class_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;

    localparam int STATUS_Z = 0;
    localparam int STATUS_N = 1;
    localparam int STATUS_C = 2;
    localparam int STATUS_V = 3;

    typedef struct packed {
        logic [3:0]   alu_op;
        logic         alu_src;
        logic         mem_to_reg;
        logic [1:0]   immselect;
        instr_class_t cls;
        logic [2:0]   funct3;
    } ctrl_t;

    // Branch outcome from the ALU flags of the SUB comparison
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] status);
        logic lt;
        lt = status[STATUS_N] ^ status[STATUS_V];
        case (funct3)
            F3_BEQ:  return status[STATUS_Z];
            F3_BNE:  return !status[STATUS_Z];
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
// Optional feature macro: SEQ_PERF_CNT_EN adds the cycle/instret counters.
interface datapath_sequencer_if;
    logic        run;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        RegWrite;
    logic        PCSrc;
    logic        ALUSrc;
    logic [3:0]  ALU_operation;
    logic        write;
    logic        MemtoReg;
    logic [1:0]  immselect;
    logic        pc_en;
    logic        busy;
    logic        halted;
    logic        illegal;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    modport master (
        input  run, instr, status,
        output RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg, immselect,
               pc_en, busy, halted, illegal
`ifdef SEQ_PERF_CNT_EN
        , output cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        output run, instr, status,
        input  RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg, immselect,
               pc_en, busy, halted, illegal
`ifdef SEQ_PERF_CNT_EN
        , input cycle_cnt, instret_cnt
`endif
    );
endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decoder: instr -> control fields, class, illegal.
module seq_decode
    import seq_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_op;
    logic       alu_ok;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices and immediate bits belong to the datapath, not to control
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // ALU operation shared by R and I formats, with funct7 legality
    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b1;
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = ALU_SRL;
            3'b010:  alu_op = ALU_SLT;
            default: alu_ok = 1'b0;
        endcase
        if (opcode == OP_R) begin
            if (!(funct7 == F7_BASE || (funct7 == F7_ALT && funct3 == 3'b000)))
                alu_ok = 1'b0;
        end else if (funct3 == 3'b101 && funct7 != F7_BASE) begin
            // I-format ignores funct7 except for the shift-right immediate
            alu_ok = 1'b0;
        end
    end

    // Per-opcode control fields
    always_comb begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.immselect  = IMM_I;
        ctrl.cls        = CLS_ALU;
        ctrl.funct3     = funct3;
        illegal         = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.alu_op     = alu_op;
                ctrl.mem_to_reg = 1'b1;
                illegal         = !alu_ok;
            end
            OP_I: begin
                ctrl.alu_op     = alu_op;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                illegal         = !alu_ok;
            end
            OP_LW: begin
                ctrl.cls     = CLS_LW;
                ctrl.alu_src = 1'b1;
                illegal      = (funct3 != F3_WORD);
            end
            OP_SW: begin
                ctrl.cls       = CLS_SW;
                ctrl.alu_src   = 1'b1;
                ctrl.immselect = IMM_S;
                illegal        = (funct3 != F3_WORD);
            end
            OP_BR: begin
                ctrl.cls       = CLS_BR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.immselect = IMM_B;
                illegal        = !(funct3 == F3_BEQ || funct3 == F3_BNE ||
                                   funct3 == F3_BLT || funct3 == F3_BGE);
            end
            OP_SYS:  ctrl.cls = CLS_HALT;
            default: illegal  = 1'b1;
        endcase
    end
endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the RV32-subset datapath.
// Optional feature macro: SEQ_PERF_CNT_EN (cycle_cnt / instret_cnt outputs).
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter bit RESET_TO_RUN = 1'b0
)
(
    input  logic                  clk,
    input  logic                  reset,
    datapath_sequencer_if.master  bus
);
    state_t state_reg;
    ctrl_t  ctrl_reg;
    ctrl_t  dec_ctrl;
    logic   dec_illegal;
    logic   reg_write_reg;
    logic   write_reg;
    logic   pc_en_reg;
    logic   illegal_reg;
    logic   unused_status;

    seq_decode u_decode (
        .instr   (bus.instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Sequencing, control-field capture in DECODE and one-cycle strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RESET_TO_RUN ? S_FETCH : S_IDLE;
            ctrl_reg      <= '0;
            reg_write_reg <= 1'b0;
            write_reg     <= 1'b0;
            pc_en_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            reg_write_reg <= 1'b0;
            write_reg     <= 1'b0;
            pc_en_reg     <= 1'b0;
            case (state_reg)
                S_IDLE:   if (bus.run) state_reg <= S_FETCH;
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: begin
                    ctrl_reg <= dec_ctrl;
                    if (dec_illegal) begin
                        state_reg   <= S_HALT;
                        illegal_reg <= 1'b1;
                    end else if (dec_ctrl.cls == CLS_HALT) begin
                        state_reg <= S_HALT;
                    end else begin
                        state_reg <= S_EXEC;
                        pc_en_reg <= (dec_ctrl.cls == CLS_BR);
                    end
                end
                S_EXEC: begin
                    case (ctrl_reg.cls)
                        CLS_BR:  state_reg <= bus.run ? S_FETCH : S_IDLE;
                        CLS_LW:  state_reg <= S_MEM;
                        CLS_SW: begin
                            state_reg <= S_MEM;
                            write_reg <= 1'b1;
                            pc_en_reg <= 1'b1;
                        end
                        default: begin
                            state_reg     <= S_WB;
                            reg_write_reg <= 1'b1;
                            pc_en_reg     <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (ctrl_reg.cls == CLS_LW) begin
                        state_reg     <= S_WB;
                        reg_write_reg <= 1'b1;
                        pc_en_reg     <= 1'b1;
                    end else begin
                        state_reg <= bus.run ? S_FETCH : S_IDLE;
                    end
                end
                S_WB:     state_reg <= bus.run ? S_FETCH : S_IDLE;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    // Strobes are masked while reset is high so an aborted instruction never
    // commits in the reset cycle. The branch decision needs the ALU flags of
    // the SUB issued in EXEC, so PCSrc is resolved in that same cycle.
    assign bus.RegWrite      = reg_write_reg & ~reset;
    assign bus.write         = write_reg & ~reset;
    assign bus.pc_en         = pc_en_reg & ~reset;
    assign bus.PCSrc         = ~reset && state_reg == S_EXEC && ctrl_reg.cls == CLS_BR &&
                               branch_taken(ctrl_reg.funct3, bus.status);
    assign bus.ALU_operation = ctrl_reg.alu_op;
    assign bus.ALUSrc        = ctrl_reg.alu_src;
    assign bus.MemtoReg      = ctrl_reg.mem_to_reg;
    assign bus.immselect     = ctrl_reg.immselect;
    assign bus.busy          = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign bus.halted        = (state_reg == S_HALT);
    assign bus.illegal       = illegal_reg;
    assign unused_status     = bus.status[STATUS_C];

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instret_cnt_reg;

    // Busy-cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (bus.busy)  cycle_cnt_reg   <= cycle_cnt_reg + 32'd1;
            if (pc_en_reg) instret_cnt_reg <= instret_cnt_reg + 32'd1;
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_reg;
    assign bus.instret_cnt = instret_cnt_reg;
`endif
endmodule
